// File: rtl/rtc_poll_pkg.sv
// rtl/rtc_poll_pkg.sv - shared types and constants for the RTC display poller
package rtc_poll_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CHECK = 2'd2
  } poll_state_t;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

  localparam int SEC_LO_LSB = 0;
  localparam int SEC_HI_LSB = 4;
  localparam int MIN_LO_LSB = 8;
  localparam int MIN_HI_LSB = 12;

  function automatic logic bcd_time_ok(input logic [15:0] t);
    return (t[SEC_LO_LSB +: 4] <= BCD_MAX_UNITS) &&
           (t[SEC_HI_LSB +: 4] <= BCD_MAX_TENS)  &&
           (t[MIN_LO_LSB +: 4] <= BCD_MAX_UNITS) &&
           (t[MIN_HI_LSB +: 4] <= BCD_MAX_TENS);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to active-low 7-segment decoder
module bcd_to_seg7
  import rtc_poll_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/rtc_display_poller.sv
// rtl/rtc_display_poller.sv - polls the RTC mm:ss word over the bus and scans it onto a 4-digit display
// Optional: COLON_BLINK_EN lights the colon on digit 2 while the seconds count is even.
module rtc_display_poller
  import rtc_poll_pkg::*;
#(
  parameter logic [31:0] RTC_ADDRESS = 32'h0000_4000,
  parameter int          POLL_COUNT  = 3600000,
  parameter int          SCAN_COUNT  = 36000,
  parameter int          TIMEOUT     = 15
) (
  input  logic        clk_in,
  input  logic        reset,
  output logic [31:0] address_out,
  output logic        sel_out,
  output logic        read_out,
  input  logic [31:0] read_value_in,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic        ready_in,
  output logic [15:0] time_out,
  output logic        valid_out,
  output logic        error_out,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  digit_sel_out
);

  localparam int PW = $clog2(POLL_COUNT + 1);
  localparam int SW = $clog2(SCAN_COUNT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_COUNT - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_COUNT - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  poll_state_t   state, state_next;
  logic [PW-1:0] poll_cnt;
  logic          poll_tick;
  logic [WW-1:0] wait_cnt;
  logic [15:0]   sample;
  logic          capture, timed_out, accept, reject;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic          dp_next;
  logic          unused_bits;

  assign address_out     = RTC_ADDRESS;
  assign write_mask_out  = 4'b0000;
  assign write_value_out = 32'h0;
  assign sel_out         = (state == REQ);
  assign read_out        = sel_out;
  assign unused_bits     = ^read_value_in[31:16];

  assign poll_tick = (poll_cnt == POLL_LAST);

  always_ff @(posedge clk_in) begin
    if (reset) poll_cnt <= '0;
    else       poll_cnt <= poll_tick ? '0 : poll_cnt + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A ready in the last allowed REQ cycle still wins over the timeout.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    timed_out  = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: if (poll_tick) state_next = REQ;
      REQ: begin
        if (ready_in) begin
          capture    = 1'b1;
          state_next = CHECK;
        end else if (wait_cnt == WAIT_LAST) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end
      end
      CHECK: begin
        accept     = bcd_time_ok(sample);
        reject     = !bcd_time_ok(sample);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wait_cnt  <= '0;
      sample    <= 16'h0000;
      time_out  <= 16'h0000;
      valid_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      wait_cnt  <= (state == REQ) ? wait_cnt + 1'b1 : '0;
      valid_out <= accept;
      if (capture)            sample    <= read_value_in[15:0];
      if (accept)             time_out  <= sample;
      if (timed_out || reject) error_out <= 1'b1;
    end
  end

  assign nibble = time_out[{digit_idx, 2'b00} +: 4];

  bcd_to_seg7 u_seg (
    .bcd (nibble),
    .seg (glyph)
  );

`ifdef COLON_BLINK_EN
  assign dp_next = !((digit_idx == 2'd2) && !time_out[SEC_LO_LSB]);
`else
  assign dp_next = 1'b1;
`endif

  // Segment, enable and colon registers are all loaded from the same index so they switch together.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      scan_cnt      <= '0;
      digit_idx     <= 2'd0;
      digit_sel_out <= 4'b1110;
      seg_out       <= SEG_0;
      dp_out        <= 1'b1;
    end else begin
      scan_cnt      <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
      if (scan_cnt == SCAN_LAST) digit_idx <= digit_idx + 2'd1;
      digit_sel_out <= ~(4'b0001 << digit_idx);
      seg_out       <= glyph;
      dp_out        <= dp_next;
    end
  end

endmodule

// File: tb/tb_rtc_display_poller.sv
// tb/tb_rtc_display_poller.sv - self-checking bench for rtc_display_poller
module tb_rtc_display_poller;

  localparam int          POLL = 20;
  localparam int          SCAN = 4;
  localparam int          TO   = 3;
  localparam logic [31:0] ADDR = 32'h0000_4000;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [31:0] address_out, read_value_in, write_value_out;
  logic        sel_out, read_out, ready_in, valid_out, error_out, dp_out;
  logic [3:0]  write_mask_out, digit_sel_out;
  logic [15:0] time_out;
  logic [6:0]  seg_out;

  rtc_display_poller #(
    .RTC_ADDRESS (ADDR),
    .POLL_COUNT  (POLL),
    .SCAN_COUNT  (SCAN),
    .TIMEOUT     (TO)
  ) dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .address_out     (address_out),
    .sel_out         (sel_out),
    .read_out        (read_out),
    .read_value_in   (read_value_in),
    .write_mask_out  (write_mask_out),
    .write_value_out (write_value_out),
    .ready_in        (ready_in),
    .time_out        (time_out),
    .valid_out       (valid_out),
    .error_out       (error_out),
    .seg_out         (seg_out),
    .dp_out          (dp_out),
    .digit_sel_out   (digit_sel_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise = 0;
  int rise_cyc = 0;

  typedef struct {
    int          delay;
    logic [31:0] data;
    int          exp_sel;
    logic [15:0] exp_time;
    logic [2:0]  exp_vmask;
    logic        exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph_of(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int nib(input logic [15:0] t, input int i);
    return (int'(t) >> (4 * i)) % 16;
  endfunction

  function automatic bit time_ok(input logic [15:0] t);
    return nib(t, 0) <= 9 && nib(t, 1) <= 5 && nib(t, 2) <= 9 && nib(t, 3) <= 5;
  endfunction

  // Responder: ready_in goes high on REQ cycle number `delay` (0 = same cycle as sel_out rises).
  task automatic do_poll(input int delay, input logic [31:0] data,
                         output int sel_cyc, output logic [2:0] vmask, output bit bus_ok);
    int n;
    n = 0;
    sel_cyc = 0;
    vmask = 3'b000;
    bus_ok = 1'b1;
    while (!sel_out && n < 40) begin
      step();
      n++;
    end
    if (!sel_out) begin
      check("poll_start_timeout", 32'd0, 32'd1);
      return;
    end
    rise_cyc = cyc;
    while (sel_out && sel_cyc < 10) begin
      if (address_out !== ADDR || read_out !== 1'b1 ||
          write_mask_out !== 4'b0 || write_value_out !== 32'h0) bus_ok = 1'b0;
      ready_in      = (sel_cyc == delay);
      read_value_in = (sel_cyc == delay) ? data : $urandom;
      step();
      sel_cyc++;
    end
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vmask[i] = valid_out;
      step();
    end
  endtask

  int          sel_cyc;
  logic [2:0]  vmask;
  bit          bus_ok;
  logic [15:0] m_time;
  logic        m_err;
  int          prev_idx, last_change, idx;
  bit          seen;

  initial begin
    vecs[0] = '{0, 32'h0000_5937, 1, 16'h5937, 3'b010, 1'b0};
    vecs[1] = '{2, 32'hABCD_0102, 3, 16'h0102, 3'b010, 1'b0};
    vecs[2] = '{5, 32'h0000_1111, 3, 16'h0102, 3'b000, 1'b1};
    vecs[3] = '{0, 32'h0000_0160, 1, 16'h0102, 3'b000, 1'b1};
    vecs[4] = '{1, 32'h0000_1234, 2, 16'h1234, 3'b010, 1'b1};

    reset = 1'b1;
    ready_in = 1'b0;
    read_value_in = 32'h0;
    repeat (3) step();
    check("rst_sel", sel_out, 1'b0);
    check("rst_read", read_out, 1'b0);
    check("rst_time", time_out, 16'h0000);
    check("rst_valid", valid_out, 1'b0);
    check("rst_err", error_out, 1'b0);
    check("rst_digit", digit_sel_out, 4'b1110);
    check("rst_seg", seg_out, 7'b1000000);
    check("rst_dp", dp_out, 1'b1);

    reset = 1'b0;
    cyc = 0;
    last_rise = 0;
    for (int v = 0; v < 5; v++) begin
      do_poll(vecs[v].delay, vecs[v].data, sel_cyc, vmask, bus_ok);
      check($sformatf("vec%0d_spacing", v), rise_cyc - last_rise, POLL);
      last_rise = rise_cyc;
      check($sformatf("vec%0d_sel_cycles", v), sel_cyc, vecs[v].exp_sel);
      check($sformatf("vec%0d_bus", v), bus_ok, 1'b1);
      check($sformatf("vec%0d_valid", v), vmask, vecs[v].exp_vmask);
      check($sformatf("vec%0d_time", v), time_out, vecs[v].exp_time);
      check($sformatf("vec%0d_err", v), error_out, vecs[v].exp_err);
    end

    // Display scan over 16'h1234: three full digit periods.
    prev_idx = -1;
    last_change = 0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      idx = -1;
      for (int i = 0; i < 4; i++) if (digit_sel_out === ~(4'b0001 << i)) idx = i;
      check("disp_onehot", (idx >= 0), 1'b1);
      if (idx >= 0) begin
        check($sformatf("disp_seg_d%0d", idx), seg_out, glyph_of(nib(16'h1234, idx)));
`ifdef COLON_BLINK_EN
        check($sformatf("disp_dp_d%0d", idx), dp_out, (idx == 2) ? 1'b0 : 1'b1);
`else
        check($sformatf("disp_dp_d%0d", idx), dp_out, 1'b1);
`endif
        if (prev_idx >= 0 && idx != prev_idx) begin
          check("disp_order", idx, (prev_idx + 1) % 4);
          if (seen) check("disp_spacing", cyc - last_change, SCAN);
          seen = 1'b1;
          last_change = cyc;
        end
        prev_idx = idx;
      end
      step();
    end

    // Reset in the middle of a wait-stated transfer, then a stray late ready.
    idx = 0;
    while (!sel_out && idx < 40) begin
      step();
      idx++;
    end
    check("midreq_sel_seen", sel_out, 1'b1);
    step();
    reset = 1'b1;
    step();
    check("midreq_sel", sel_out, 1'b0);
    check("midreq_time", time_out, 16'h0000);
    check("midreq_err", error_out, 1'b0);
    check("midreq_valid", valid_out, 1'b0);
    check("midreq_digit", digit_sel_out, 4'b1110);
    check("midreq_seg", seg_out, 7'b1000000);
    reset = 1'b0;
    cyc = 0;
    last_rise = 0;
    ready_in = 1'b1;
    read_value_in = 32'h0000_0945;
    bus_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (sel_out !== 1'b0 || valid_out !== 1'b0 || time_out !== 16'h0000) bus_ok = 1'b0;
    end
    ready_in = 1'b0;
    check("late_ready_ignored", bus_ok, 1'b1);

    // Randomized polls against a per-transaction model.
    m_time = 16'h0000;
    m_err  = 1'b0;
    for (int r = 0; r < 20; r++) begin
      int          d;
      logic [15:0] lo;
      bit          ok;
      d  = $urandom_range(0, 4);
      lo = 16'(($urandom_range(0, 6) << 12) | ($urandom_range(0, 10) << 8) |
                ($urandom_range(0, 6) << 4) | $urandom_range(0, 10));
      do_poll(d, {16'($urandom), lo}, sel_cyc, vmask, bus_ok);
      ok = (d < TO) && time_ok(lo);
      if (ok) m_time = lo;
      else    m_err  = 1'b1;
      check($sformatf("rnd%0d_spacing", r), rise_cyc - last_rise, POLL);
      last_rise = rise_cyc;
      check($sformatf("rnd%0d_sel_cycles", r), sel_cyc, (d < TO) ? d + 1 : TO);
      check($sformatf("rnd%0d_bus", r), bus_ok, 1'b1);
      check($sformatf("rnd%0d_valid", r), vmask, ok ? 3'b010 : 3'b000);
      check($sformatf("rnd%0d_time", r), time_out, m_time);
      check($sformatf("rnd%0d_err", r), error_out, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
